// File: rtl/uart_cmd_decoder.sv
// Decodes "!<letter>[digit]<CR|LF>" frames from a UART byte stream into
// one-cycle action pulses, optionally repeated with a fixed gap between them.
module uart_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 27_000_000,
  parameter int PULSE_GAP      = 1_350_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  output logic       feed,
  output logic       play,
  output logic       clean,
  output logic       sleep,
  output logic       busy,
  output logic       err,
  output logic [7:0] last_cmd
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(PULSE_GAP + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(PULSE_GAP);

  typedef enum logic [2:0] {IDLE, CMD, ARG, TERM, EXEC} state_t;

  state_t        state, state_nx;
  logic [7:0]    prev_byte;
  logic [1:0]    code, code_nx;
  logic [3:0]    count, count_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [GW-1:0] gap, gap_nx;
  logic [7:0]    last_nx;
  logic          fire, err_nx;
  logic          accept, is_term, is_digit, is_letter;
  logic [1:0]    letter_code;

  assign accept   = (rx_byte != 8'h00) && (prev_byte == 8'h00);
  assign is_term  = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
  assign is_digit = (rx_byte >= 8'h31) && (rx_byte <= 8'h39);
  assign busy     = (state != IDLE);

  function automatic logic [7:0] code_ascii(input logic [1:0] c);
    case (c)
      2'd0:    code_ascii = 8'h46;
      2'd1:    code_ascii = 8'h50;
      2'd2:    code_ascii = 8'h43;
      default: code_ascii = 8'h53;
    endcase
  endfunction

  always_comb begin
    is_letter   = 1'b1;
    letter_code = 2'd0;
    case (rx_byte)
      8'h46:   letter_code = 2'd0;
      8'h50:   letter_code = 2'd1;
      8'h43:   letter_code = 2'd2;
      8'h53:   letter_code = 2'd3;
      default: is_letter = 1'b0;
    endcase
  end

  // count holds the pulses still owed after the one being fired
  always_comb begin
    state_nx = state;
    code_nx  = code;
    count_nx = count;
    timer_nx = timer;
    gap_nx   = gap;
    last_nx  = last_cmd;
    fire     = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && rx_byte == 8'h21) begin
          state_nx = CMD;
          timer_nx = '0;
        end
      end
      CMD, ARG, TERM: begin
        if (accept) begin
          timer_nx = '0;
          state_nx = IDLE;
          if (state == CMD && is_letter) begin
            code_nx  = letter_code;
            count_nx = 4'd1;
            state_nx = ARG;
          end else if (state == CMD && rx_byte == 8'h21) begin
            state_nx = CMD;
          end else if (state == ARG && is_digit) begin
            count_nx = rx_byte[3:0];
            state_nx = TERM;
          end else if (state != CMD && is_term) begin
            fire     = 1'b1;
            last_nx  = code_ascii(code);
            count_nx = count - 4'd1;
            gap_nx   = '0;
            state_nx = (count == 4'd1) ? IDLE : EXEC;
          end else begin
            err_nx = 1'b1;
          end
        end else if (timer == TIMER_LAST) begin
          err_nx   = 1'b1;
          timer_nx = '0;
          state_nx = IDLE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      EXEC: begin
        err_nx = accept;
        if (gap == GAP_LAST) begin
          fire     = 1'b1;
          gap_nx   = '0;
          count_nx = count - 4'd1;
          if (count == 4'd1) state_nx = IDLE;
        end else begin
          gap_nx = gap + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev_byte <= 8'h00;
      code      <= 2'd0;
      count     <= 4'd0;
      timer     <= '0;
      gap       <= '0;
      last_cmd  <= 8'h00;
      err       <= 1'b0;
      feed      <= 1'b0;
      play      <= 1'b0;
      clean     <= 1'b0;
      sleep     <= 1'b0;
    end else begin
      state     <= state_nx;
      prev_byte <= rx_byte;
      code      <= code_nx;
      count     <= count_nx;
      timer     <= timer_nx;
      gap       <= gap_nx;
      last_cmd  <= last_nx;
      err       <= err_nx;
      feed      <= fire && (code == 2'd0);
      play      <= fire && (code == 2'd1);
      clean     <= fire && (code == 2'd2);
      sleep     <= fire && (code == 2'd3);
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed frames plus random traffic,
// compared every cycle against a time-scheduled protocol model.
module tb_uart_cmd_decoder;

  localparam int TO  = 100;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       feed, play, clean, sleep, busy, err;
  logic [7:0] last_cmd;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(TO), .PULSE_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte),
    .feed(feed), .play(play), .clean(clean), .sleep(sleep),
    .busy(busy), .err(err), .last_cmd(last_cmd)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int n_feed, n_play, n_clean, n_sleep, n_err;
  int err_times[$];
  int pulse_times[$];
  logic [7:0] prev_drv = 8'h00;

  // Model: parse position, scheduled pulse times in absolute cycles
  int         phase = 0;
  int         last_act = 0;
  int         reps = 0;
  int         exec_left = 0;
  int         exec_next = 0;
  logic [7:0] m_letter = 8'h00;
  logic [7:0] m_exec_letter = 8'h00;
  logic [7:0] m_last = 8'h00;
  logic [3:0] m_act = 4'd0;
  logic       m_err = 1'b0;

  function automatic logic [3:0] onehot(input logic [7:0] l);
    case (l)
      8'h46:   onehot = 4'b1000;
      8'h50:   onehot = 4'b0100;
      8'h43:   onehot = 4'b0010;
      8'h53:   onehot = 4'b0001;
      default: onehot = 4'b0000;
    endcase
  endfunction

  function automatic bit is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  task automatic resetModel();
    phase = 0; exec_left = 0; m_last = 8'h00;
    m_act = 4'd0; m_err = 1'b0; prev_drv = 8'h00;
  endtask

  task automatic startExec();
    m_act = onehot(m_letter);
    m_last = m_letter;
    m_exec_letter = m_letter;
    exec_left = reps - 1;
    exec_next = cyc + GAP + 1;
    phase = 0;
  endtask

  task automatic modelEdge(input bit acc, input logic [7:0] b);
    m_act = 4'd0;
    m_err = 1'b0;
    if (exec_left > 0) begin
      if (cyc == exec_next) begin
        m_act = onehot(m_exec_letter);
        exec_left--;
        exec_next += GAP + 1;
      end
      if (acc) m_err = 1'b1;
    end else if (acc) begin
      case (phase)
        0: if (b == 8'h21) begin phase = 1; last_act = cyc; end
        1: begin
          if (onehot(b) != 4'd0) begin m_letter = b; reps = 1; phase = 2; last_act = cyc; end
          else if (b == 8'h21) last_act = cyc;
          else begin m_err = 1'b1; phase = 0; end
        end
        2: begin
          if (b >= 8'h31 && b <= 8'h39) begin reps = int'(b) - 48; phase = 3; last_act = cyc; end
          else if (is_term(b)) startExec();
          else begin m_err = 1'b1; phase = 0; end
        end
        default: begin
          if (is_term(b)) startExec();
          else begin m_err = 1'b1; phase = 0; end
        end
      endcase
    end else if (phase != 0 && cyc - last_act == TO) begin
      m_err = 1'b1;
      phase = 0;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [13:0] obs, exp;
    obs = {feed, play, clean, sleep, err, busy, last_cmd};
    exp = {m_act, m_err, (phase != 0 || exec_left > 0), m_last};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearCounts();
    n_feed = 0; n_play = 0; n_clean = 0; n_sleep = 0; n_err = 0;
    err_times.delete();
    pulse_times.delete();
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      resetModel();
    end else begin
      acc = (rx_byte != 8'h00) && (prev_drv == 8'h00);
      prev_drv = rx_byte;
      if (acc) last_acc_cyc = cyc;
      modelEdge(acc, rx_byte);
    end
    #1;
    checkOutput("cycle");
    n_feed += int'(feed); n_play += int'(play);
    n_clean += int'(clean); n_sleep += int'(sleep); n_err += int'(err);
    if (err) err_times.push_back(cyc);
    if (feed | play | clean | sleep) pulse_times.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int hold, input int gap);
    rx_byte = b;
    repeat (hold) tick();
    rx_byte = 8'h00;
    repeat (gap) tick();
  endtask

  // '~' stands for CR and '|' for LF inside frame strings
  task automatic sendFrame(input string s, input int hold, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      c = s[i];
      if (c == 8'h7E) c = 8'h0D;
      else if (c == 8'h7C) c = 8'h0A;
      applyStimulus(c, hold, gap);
    end
  endtask

  initial begin
    logic [7:0] letters [6];
    logic [7:0] fr [$];
    letters = '{8'h46, 8'h50, 8'h43, 8'h53, 8'h58, 8'h66};
    clearCounts();

    #1 rst_n = 1'b0;
    resetModel();
    #1 checkOutput("reset_state");
    idle(2);
    #2 rst_n = 1'b1;
    idle(3);

    clearCounts();
    sendFrame("!F~", 10, 5);
    idle(5);
    checkCount("feed_once", n_feed, 1);
    checkCount("feed_no_err", n_err, 0);
    checkCount("feed_last_cmd", int'(last_cmd), 32'h46);
    checkCount("feed_busy_after", int'(busy), 0);

    clearCounts();
    sendFrame("!P3|", 2, 1);
    idle(25);
    checkCount("play_count", n_play, 3);
    if (pulse_times.size() != 3) pulse_times = '{0, 0, 0};
    checkCount("play_gap_1", pulse_times[1] - pulse_times[0], GAP + 1);
    checkCount("play_gap_2", pulse_times[2] - pulse_times[1], GAP + 1);

    clearCounts();
    sendFrame("!X~", 3, 2);
    idle(5);
    checkCount("bad_letter_err", n_err, 1);
    checkCount("bad_letter_no_action", n_feed + n_play + n_clean + n_sleep, 0);
    clearCounts();
    sendFrame("!!C~", 3, 2);
    idle(5);
    checkCount("restart_clean", n_clean, 1);
    checkCount("restart_no_err", n_err, 0);

    clearCounts();
    applyStimulus(8'h21, 4, 0);
    idle(110);
    checkCount("timeout_err", n_err, 1);
    if (err_times.size() == 0) err_times.push_back(0);
    checkCount("timeout_cycle", err_times[0] - last_acc_cyc, TO);
    clearCounts();
    sendFrame("!S~", 2, 2);
    idle(5);
    checkCount("post_timeout_sleep", n_sleep, 1);

    clearCounts();
    sendFrame("!C9~", 2, 1);
    idle(6);
    applyStimulus(8'h51, 2, 1);
    idle(60);
    checkCount("overrun_clean", n_clean, 9);
    checkCount("overrun_err", n_err, 1);

    clearCounts();
    sendFrame("!C9~", 2, 1);
    for (int k = 0; k < 50 && n_clean < 2; k++) tick();
    checkCount("pre_reset_pulses", n_clean, 2);
    #2 rst_n = 1'b0;
    resetModel();
    #1 checkOutput("async_reset");
    idle(3);
    #2 rst_n = 1'b1;
    clearCounts();
    idle(60);
    checkCount("aborted_pulses", n_clean, 0);

    #2 rst_n = 1'b0;
    resetModel();
    rx_byte = 8'h21;
    idle(2);
    #2 rst_n = 1'b1;
    clearCounts();
    tick();
    rx_byte = 8'h00;
    tick();
    sendFrame("F~", 2, 2);
    idle(5);
    checkCount("held_byte_after_reset", n_feed, 1);

    for (int f = 0; f < 40; f++) begin
      fr.delete();
      if ($urandom_range(0, 7) != 0) fr.push_back(8'h21);
      fr.push_back(letters[$urandom_range(0, 5)]);
      if ($urandom_range(0, 1) == 1) fr.push_back(8'h30 + 8'($urandom_range(0, 9)));
      case ($urandom_range(0, 5))
        0, 1, 2: fr.push_back(8'h0D);
        3, 4:    fr.push_back(8'h0A);
        default: fr.push_back(8'h5A);
      endcase
      foreach (fr[i]) applyStimulus(fr[i], $urandom_range(1, 4), $urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) idle(110);
      else idle($urandom_range(0, 50));
    end
    idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 27_000_000, is the maximum idle cycles allowed between bytes of a partial command (1 s at 27 MHz).
REQ-002 Parameter PULSE_GAP, default 1_350_000, is the idle cycles between repeated action pulses (50 ms); legal range >= 1.
REQ-003 clk  input  1  system clock, 27 MHz; the block is single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_byte  input  8  received byte from the UART receiver; non-zero while a byte is valid, 8'h00 otherwise.
REQ-006 feed  output  1  one-cycle action pulse for the hunger action.
REQ-007 play  output  1  one-cycle action pulse for the happiness action.
REQ-008 clean  output  1  one-cycle action pulse for the hygiene action.
REQ-009 sleep  output  1  one-cycle action pulse that toggles the sleep request.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 err  output  1  one-cycle pulse on any protocol error, timeout or overrun.
REQ-012 last_cmd  output  8  ASCII letter of the last successfully executed command.

Function
REQ-013 Byte strobe: a byte is accepted on the clock edge where rx_byte != 0 and the registered previous rx_byte == 0; a held non-zero value is never re-accepted.
REQ-014 Frame format: '!' (8'h21), command letter, optional repeat digit '1'-'9', then terminator '\r' (8'h0D) or '\n' (8'h0A).
REQ-015 Command letters map as follows: 'F' to feed, 'P' to play, 'C' to clean, 'S' to sleep. Letters are uppercase only.
REQ-016 FSM states: IDLE, CMD, ARG, TERM, EXEC.
REQ-017 IDLE: '!' goes to CMD; any other byte is ignored silently.
REQ-018 CMD: a valid letter stores the code, sets count=1 and goes to ARG; '!' stays in CMD as a restart; any other byte pulses err and returns to IDLE.
REQ-019 ARG: a digit '1'-'9' sets count to that value and goes to TERM; a terminator goes to EXEC; '0', '!' or any other byte pulses err and returns to IDLE.
REQ-020 TERM: a terminator goes to EXEC; any other byte pulses err and returns to IDLE.
REQ-021 Timeout: in CMD, ARG and TERM, a cycle counter clears on every accepted byte and on state entry; when it reaches TIMEOUT_CYCLES it pulses err and returns to IDLE.
REQ-022 EXEC: the selected output pulses high for exactly 1 cycle, count times.
REQ-023 EXEC timing: the first pulse is high in the cycle after the edge that accepted the terminator; successive pulse rising edges are exactly PULSE_GAP+1 cycles apart; after the last pulse the FSM returns to IDLE on that same edge.
REQ-024 Overrun: a byte accepted in EXEC is dropped, pulses err, and does not disturb the pulse sequence.
REQ-025 last_cmd updates on entry to EXEC.
REQ-026 Exclusivity: at most one of feed, play, clean and sleep is high in any cycle; err is never high in the same cycle as an action pulse caused by the same byte.
REQ-027 Repeat count is a 4-bit register; the internal counters are sized for their parameter values, with no wrap-around before terminal count.

Reset
REQ-028 While rst_n is low, all outputs and registers are cleared asynchronously: FSM to IDLE, feed, play, clean, sleep, err and busy to 0, last_cmd to 8'h00, previous-byte register to 8'h00, counters to 0.
REQ-029 Reset asserted mid-EXEC aborts the remaining pulses.
REQ-030 After rst_n deasserts, a rx_byte already non-zero is accepted on the first clock edge, because the previous-byte register is 0.

Verification
REQ-031 Bytes "!F\r", each held 10 cycles with 5-cycle gaps -> feed high exactly 1 cycle, last_cmd=8'h46, err never high, busy low afterwards.
REQ-032 "!P3\n" with PULSE_GAP=4 -> exactly 3 play pulses, rising edges 5 cycles apart, busy drops on the third pulse edge.
REQ-033 "!X\r" -> err pulse on 'X', no action pulse, and '\r' ignored in IDLE; also "!!C\r" -> one clean pulse.
REQ-034 '!' then no bytes for TIMEOUT_CYCLES (set to 100) -> err at cycle 100, FSM in IDLE; a following "!S\r" -> one sleep pulse.
REQ-035 "!C9\r" then a byte during EXEC -> err pulse, all 9 clean pulses delivered; separately, rst_n low after 2 pulses -> outputs 0 immediately and no further pulses.
